iiitb_brg_prog: RTL and testbench

//  Programmable baud-rate generator; successor to the fixed four-rate BRG.

---
 rtl/iiitb_brg_pkg.sv | 17 +
 rtl/iiitb_brg_divider.sv | 119 +++++++++++
 rtl/iiitb_brg_prog.sv | 67 ++++++
 tb/tb_iiitb_brg_prog.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_brg_pkg.sv
// Shared constants for the programmable baud-rate generator.
// Optional fractional divider is enabled with `define BRG_FRAC_EN.
package iiitb_brg_pkg;

   localparam int BRG_DIV_W       = 16;
   localparam int BRG_OVS         = 16;
   localparam int BRG_DEFAULT_DIV = 27;
   localparam int BRG_FRAC_W      = 4;

   // Width of the oversample sub-counter (counts 0..ovs-1)
   function automatic int sub_width(input int ovs);
      return (ovs <= 2) ? 1 : $clog2(ovs);
   endfunction

   localparam int BRG_SUB_W = sub_width(BRG_OVS);

endpackage

// File: rtl/iiitb_brg_divider.sv
// Oversample divider: os_cnt, shadow/active divisor, optional fractional
// accumulator (`define BRG_FRAC_EN), registered os_tick.
module iiitb_brg_divider
   import iiitb_brg_pkg::*;
#(
   parameter int DIV_W       = BRG_DIV_W,
   parameter int FRAC_W      = BRG_FRAC_W,
   parameter int DEFAULT_DIV = BRG_DEFAULT_DIV
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sync,
   input  logic              div_load,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              cfg_pending,
   output logic              os_tick
);

   logic [DIV_W-1:0] os_cnt;
   logic [DIV_W-1:0] active_div;
   logic [DIV_W-1:0] shadow_div;
   logic [DIV_W-1:0] new_div;
   logic [DIV_W-1:0] term;
   logic             run;
   logic             at_term;
   logic             apply;
   logic             stretch;

`ifdef BRG_FRAC_EN
   logic [FRAC_W-1:0] active_frac;
   logic [FRAC_W-1:0] shadow_frac;
   logic [FRAC_W-1:0] new_frac;
   logic [FRAC_W-1:0] frac_acc;
   logic [FRAC_W:0]   acc_sum;

   assign new_frac = div_load ? div_frac : shadow_frac;
   assign acc_sum  = {1'b0, frac_acc} + {1'b0, active_frac};
`else
   logic unused_frac;

   assign unused_frac = ^div_frac;
   assign stretch     = 1'b0;
`endif

   assign new_div = div_load ? div_int : shadow_div;
   assign run     = en && (active_div != '0);
   // stretch adds one clock to the period after an accumulator carry
   assign term    = active_div - DIV_W'(1) + {{(DIV_W-1){1'b0}}, stretch};
   assign at_term = (os_cnt >= term);

   // Decide when the shadow (or a coincident load) becomes the active divisor:
   // at a wrap, whenever the generator is stalled, or together with sync.
   always_comb begin
      apply = 1'b0;
      if (sync) begin
         apply = div_load;
      end else if (!run || at_term) begin
         apply = div_load || cfg_pending;
      end
   end

   // Counter, divisor registers and tick generation
   always_ff @(posedge clk) begin
      if (!reset) begin
         os_cnt      <= '0;
         active_div  <= DIV_W'(DEFAULT_DIV);
         shadow_div  <= DIV_W'(DEFAULT_DIV);
         cfg_pending <= 1'b0;
         os_tick     <= 1'b0;
`ifdef BRG_FRAC_EN
         active_frac <= '0;
         shadow_frac <= '0;
         frac_acc    <= '0;
         stretch     <= 1'b0;
`endif
      end else begin
         os_tick <= 1'b0;

         if (div_load) begin
            shadow_div <= div_int;
`ifdef BRG_FRAC_EN
            shadow_frac <= div_frac;
`endif
         end

         if (apply) begin
            active_div  <= new_div;
            cfg_pending <= 1'b0;
`ifdef BRG_FRAC_EN
            active_frac <= new_frac;
`endif
         end else if (div_load) begin
            cfg_pending <= 1'b1;
         end

         if (sync) begin
            os_cnt <= '0;
`ifdef BRG_FRAC_EN
            frac_acc <= '0;
            stretch  <= 1'b0;
`endif
         end else if (run) begin
            if (at_term) begin
               os_cnt  <= '0;
               os_tick <= 1'b1;
`ifdef BRG_FRAC_EN
               frac_acc <= acc_sum[FRAC_W-1:0];
               stretch  <= acc_sum[FRAC_W];
`endif
            end else begin
               os_cnt <= os_cnt + DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/iiitb_brg_prog.sv
// Programmable baud-rate generator top: oversample sub-counter, baud tick,
// 50% baud clock, en/sync gating. Fractional divisor with `define BRG_FRAC_EN.
module iiitb_brg_prog
   import iiitb_brg_pkg::*;
#(
   parameter int DIV_W       = BRG_DIV_W,
   parameter int OVS         = BRG_OVS,
   parameter int DEFAULT_DIV = BRG_DEFAULT_DIV,
   parameter int FRAC_W      = BRG_FRAC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sync,
   input  logic              div_load,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              cfg_pending,
   output logic              os_tick,
   output logic              baud_tick,
   output logic              baud_clk
);

   localparam int SUB_W = sub_width(OVS);

   logic             os_raw;
   logic [SUB_W-1:0] sub_cnt;

   iiitb_brg_divider #(
      .DIV_W       (DIV_W),
      .FRAC_W      (FRAC_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_divider (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .sync        (sync),
      .div_load    (div_load),
      .div_int     (div_int),
      .div_frac    (div_frac),
      .cfg_pending (cfg_pending),
      .os_tick     (os_raw)
   );

   // A tick registered just before en dropped must not escape while frozen
   assign os_tick   = os_raw && en;
   assign baud_tick = os_tick && (sub_cnt == SUB_W'(OVS-1));

   // Oversample sub-counter and baud clock phase
   always_ff @(posedge clk) begin
      if (!reset) begin
         sub_cnt  <= '0;
         baud_clk <= 1'b0;
      end else if (sync) begin
         sub_cnt  <= '0;
         baud_clk <= 1'b0;
      end else if (os_tick) begin
         sub_cnt <= (sub_cnt == SUB_W'(OVS-1)) ? '0 : sub_cnt + SUB_W'(1);
         if (sub_cnt == SUB_W'(OVS/2-1)) begin
            baud_clk <= 1'b1;
         end else if (sub_cnt == SUB_W'(OVS-1)) begin
            baud_clk <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iiitb_brg_prog.sv
// Directed self-checking bench for iiitb_brg_prog.
// Build with +define+BRG_FRAC_EN to exercise the fractional divider.
module tb_iiitb_brg_prog;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        sync;
   logic        div_load;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic        cfg_pending;
   logic        os_tick;
   logic        baud_tick;
   logic        baud_clk;

   int n_checks = 0;
   int n_errors = 0;

   iiitb_brg_prog dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .sync        (sync),
      .div_load    (div_load),
      .div_int     (div_int),
      .div_frac    (div_frac),
      .cfg_pending (cfg_pending),
      .os_tick     (os_tick),
      .baud_tick   (baud_tick),
      .baud_clk    (baud_clk)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Rising edges until os_tick is seen; -1 if the limit expires
   task automatic count_to_os(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!os_tick && n < limit);
      if (!os_tick) n = -1;
   endtask

   task automatic count_to_baud(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!baud_tick && n < limit);
      if (!baud_tick) n = -1;
   endtask

   // Samples spent at level lvl; optionally first skip the current lvl run
   task automatic level_width(input logic lvl, input logic skip_cur, input int limit, output int n);
      int guard;
      guard = 0;
      while (skip_cur && baud_clk === lvl && guard < limit) begin
         @(negedge clk);
         guard++;
      end
      while (baud_clk !== lvl && guard < 2*limit) begin
         @(negedge clk);
         guard++;
      end
      n = 0;
      while (baud_clk === lvl && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic load(input int d, input int f, input logic with_sync);
      div_int  = 16'(d);
      div_frac = 4'(f);
      div_load = 1'b1;
      sync     = with_sync;
      @(negedge clk);
      div_load = 1'b0;
      sync     = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int sum;
      int seen;

      reset = 1'b0; en = 1'b0; sync = 1'b0; div_load = 1'b0;
      div_int = '0; div_frac = '0;
      repeat (3) @(negedge clk);

      // 1: reset state and default divisor
      check_val("rst_os_tick", int'(os_tick), 0);
      check_val("rst_baud_tick", int'(baud_tick), 0);
      check_val("rst_baud_clk", int'(baud_clk), 0);
      check_val("rst_pending", int'(cfg_pending), 0);
      reset = 1'b1; en = 1'b1;
      count_to_os(100, n);   check_val("first_os", n, 27);
      count_to_os(100, n);   check_val("os_period27", n, 27);
      count_to_baud(1000, n); check_val("first_baud", n, 14*27);
      count_to_baud(1000, n); check_val("baud_period", n, 432);
      level_width(1'b1, 1'b1, 1000, n); check_val("baud_clk_hi", n, 216);
      level_width(1'b0, 1'b0, 1000, n); check_val("baud_clk_lo", n, 216);

      // 2: reload mid-period stays pending until the current wrap
      count_to_os(100, n);
      repeat (10) @(negedge clk);
      load(4, 0, 1'b0);
      check_val("pending_set", int'(cfg_pending), 1);
      count_to_os(100, n);   check_val("wrap_after_load", n, 16);
      check_val("pending_clr", int'(cfg_pending), 0);
      count_to_os(100, n);   check_val("os_period4", n, 4);
      count_to_os(100, n);   check_val("os_period4b", n, 4);

      // 3: divisor 0 stops, divisor 1 ticks every clock
      load(0, 0, 1'b0);
      check_val("pending_div0", int'(cfg_pending), 1);
      count_to_os(20, n);    check_val("wrap_into_div0", n, 3);
      count_to_os(60, n);    check_val("div0_no_tick", n, -1);
      check_val("div0_pending", int'(cfg_pending), 0);
      load(1, 0, 1'b0);
      count_to_os(5, n);     check_val("div1_first", n, 1);
      count_to_os(5, n);     check_val("div1_period", n, 1);
      count_to_baud(40, n);
      count_to_baud(40, n);  check_val("div1_baud", n, 16);

      // 4: sync at sub_cnt = 9 restarts the baud phase
      load(5, 0, 1'b0);
      check_val("load_at_wrap_pending", int'(cfg_pending), 0);
      count_to_baud(200, n);
      for (int i = 0; i < 9; i++) count_to_os(20, n);
      check_val("os_period5", n, 5);
      @(negedge clk);
      check_val("pre_sync_baud_clk", int'(baud_clk), 1);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      check_val("sync_baud_clk", int'(baud_clk), 0);
      check_val("sync_no_tick", int'(os_tick), 0);
      count_to_baud(200, n); check_val("sync_to_baud", n, 80);

      // 5: fractional divisor 4 + 8/16 (whole periods when disabled)
      load(4, 8, 1'b1);
      count_to_os(20, n);    check_val("frac_p1", n, 4);
      count_to_os(20, n);    check_val("frac_p2", n, 4);
      sum = 0;
      for (int i = 0; i < 32; i++) begin
         count_to_os(20, n);
`ifdef BRG_FRAC_EN
         if (i == 0) check_val("frac_p3", n, 5);
         if (i == 1) check_val("frac_p4", n, 4);
`endif
         sum += n;
      end
`ifdef BRG_FRAC_EN
      check_val("frac_32_ticks", sum, 144);
`else
      check_val("frac_32_ticks", sum, 128);
`endif

      // 6: freeze with en=0, load while frozen, resume, then reset mid-load
      load(27, 0, 1'b1);
      count_to_os(100, n);   check_val("resync27", n, 27);
      repeat (10) @(negedge clk);
      en = 1'b0;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) begin
            div_int = 16'd27; div_load = 1'b1;
         end else begin
            div_load = 1'b0;
         end
         @(negedge clk);
         if (os_tick || baud_tick) seen++;
         if (i == 20) check_val("frozen_load_applied", int'(cfg_pending), 0);
      end
      check_val("frozen_ticks", seen, 0);
      check_val("frozen_baud_clk", int'(baud_clk), 0);
      en = 1'b1;
      count_to_os(100, n);   check_val("resume_phase", n, 17);
      load(7, 0, 1'b0);
      check_val("pending_before_rst", int'(cfg_pending), 1);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst2_pending", int'(cfg_pending), 0);
      check_val("rst2_os_tick", int'(os_tick), 0);
      check_val("rst2_baud_clk", int'(baud_clk), 0);
      reset = 1'b1;
      count_to_os(100, n);   check_val("rst2_first_os", n, 27);
      count_to_os(100, n);   check_val("rst2_period", n, 27);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
